// File: rtl/spi_reg_ctrl.sv
// SPI frame decoder: a command byte followed by write-data or read-dummy bytes becomes register-bank accesses.
// Define SPI_REG_CTRL_AUTOINC_EN to advance reg_addr after every data byte of a burst (otherwise FIFO-style).
module spi_reg_ctrl #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ss,
   input  logic                   rx_valid,
   input  logic [DATA_W-1:0]      rx_byte,
   output logic [DATA_W-1:0]      tx_byte,
   output logic                   tx_load,
   output logic [ADDR_W-1:0]      reg_addr,
   output logic [DATA_W-1:0]      reg_wdata,
   output logic                   reg_we,
   output logic                   reg_re,
   input  logic [DATA_W-1:0]      reg_rdata,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic [7:0]             err_cnt
);

   typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_FETCH, RD_WAIT, RD_DATA} state_t;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif
   localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = FRAME_CNT_W'(1);

   state_t                 r_state;
   logic                   r_ssPrev;
   logic [DATA_W-1:0]      r_txByte;
   logic                   r_txLoad;
   logic [ADDR_W-1:0]      r_addr;
   logic [DATA_W-1:0]      r_wdata;
   logic                   r_we;
   logic                   r_re;
   logic [FRAME_CNT_W-1:0] r_frameCnt;
   logic [7:0]             r_errCnt;

   state_t                 w_stateNext;
   logic [DATA_W-1:0]      w_txByteNext;
   logic                   w_txLoadNext;
   logic [ADDR_W-1:0]      w_addrNext;
   logic [DATA_W-1:0]      w_wdataNext;
   logic                   w_weNext;
   logic                   w_reNext;
   logic [FRAME_CNT_W-1:0] w_frameCntNext;
   logic [7:0]             w_errCntNext;
   logic                   w_errInc;

   // Strobes are registered together with the state change so reg_re lines up with RD_FETCH.
   always_comb begin
      w_stateNext    = r_state;
      w_txByteNext   = r_txByte;
      w_txLoadNext   = 1'b0;
      w_addrNext     = r_addr;
      w_wdataNext    = r_wdata;
      w_weNext       = 1'b0;
      w_reNext       = 1'b0;
      w_frameCntNext = r_frameCnt;
      w_errCntNext   = r_errCnt;
      w_errInc       = 1'b0;

      if (r_we) begin
         w_addrNext = r_addr + ADDR_STEP;
      end

      if (r_state != IDLE && ss) begin
         w_stateNext = IDLE;
         if (r_state == CMD) begin
            w_errInc = 1'b1;
         end else begin
            w_frameCntNext = r_frameCnt + FRAME_ONE;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (!ss && r_ssPrev) begin
                  w_stateNext  = CMD;
                  w_txByteNext = '0;
                  w_txLoadNext = 1'b1;
               end
            end
            CMD: begin
               if (rx_valid) begin
                  w_addrNext = rx_byte[ADDR_W-1:0];
                  if (rx_byte[DATA_W-1]) begin
                     w_stateNext = RD_FETCH;
                     w_reNext    = 1'b1;
                  end else begin
                     w_stateNext = WR_DATA;
                  end
               end
            end
            WR_DATA: begin
               if (rx_valid) begin
                  w_wdataNext = rx_byte;
                  w_weNext    = 1'b1;
               end
            end
            RD_FETCH: begin
               w_errInc    = rx_valid;
               w_stateNext = RD_WAIT;
            end
            RD_WAIT: begin
               w_errInc     = rx_valid;
               w_txByteNext = reg_rdata;
               w_txLoadNext = 1'b1;
               w_stateNext  = RD_DATA;
            end
            RD_DATA: begin
               if (rx_valid) begin
                  w_addrNext  = r_addr + ADDR_STEP;
                  w_stateNext = RD_FETCH;
                  w_reNext    = 1'b1;
               end
            end
            default: w_stateNext = IDLE;
         endcase
      end

      if (w_errInc && r_errCnt != 8'hFF) begin
         w_errCntNext = r_errCnt + 8'd1;
      end
   end

   // ss history keeps tracking through reset so a held-low ss cannot fake a frame start.
   always_ff @(posedge clk) begin
      r_ssPrev <= ss;
      if (rst) begin
         r_state    <= IDLE;
         r_txByte   <= '0;
         r_txLoad   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_re       <= 1'b0;
         r_frameCnt <= '0;
         r_errCnt   <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_txByte   <= w_txByteNext;
         r_txLoad   <= w_txLoadNext;
         r_addr     <= w_addrNext;
         r_wdata    <= w_wdataNext;
         r_we       <= w_weNext;
         r_re       <= w_reNext;
         r_frameCnt <= w_frameCntNext;
         r_errCnt   <= w_errCntNext;
      end
   end

   assign tx_byte   = r_txByte;
   assign tx_load   = r_txLoad;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_we    = r_we;
   assign reg_re    = r_re;
   assign busy      = (r_state != IDLE);
   assign frame_cnt = r_frameCnt;
   assign err_cnt   = r_errCnt;

endmodule
